joystick_controller: RTL and testbench

//  - Conditions raw active-high joystick/button lines into clean one-cycle command pulses
//    (control_up, control_down, control_select) consumed by menus and paddle logic.
//  - Sits between board pins and the menu/game FSMs: 2-flop synchronizer, per-button

---
 rtl/joystick_controller.sv | 116 +++++++++++
 tb/tb_joystick_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_controller.sv
// Joystick/button conditioner: 2-flop sync, per-button debounce, press pulses, up/down conflict masking.
// Define JOYSTICK_REPEAT_EN to enable hold-to-repeat on up/down.
module joystick_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_select_raw,
  output logic       control_up,
  output logic       control_down,
  output logic       control_select,
  output logic [2:0] held
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2 || CNT_W < 2) begin : g_param_check
    $error("joystick_controller: invalid parameter set");
  end

  // Bit order everywhere: {select, down, up}
  logic [2:0] raw;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] db;
  logic [2:0] db_next;
  logic [2:0] accept;
  logic [2:0] rise;
  logic [1:0] rep_fire;

  assign raw = {btn_select_raw, btn_down_raw, btn_up_raw};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CNT_W-1:0] cnt;

    assign accept[i] = (s2[i] != db[i]) && (cnt == DB_LAST);

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
      end else if ((s2[i] == db[i]) || accept[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign db_next = (db & ~accept) | (s2 & accept);
  assign rise    = accept & s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      db <= '0;
    end else begin
      db <= db_next;
    end
  end

  assign held = db;

`ifdef JOYSTICK_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

  // Down-counter reloads on the press pulse and on every repeat; fires on terminal count.
  for (genvar i = 0; i < 2; i++) begin : g_rpt
    logic [CNT_W-1:0] rpt;

    assign rep_fire[i] = db[i] && db_next[i] && (rpt == '0);

    always_ff @(posedge clock) begin
      if (reset || !db_next[i]) begin
        rpt <= '0;
      end else if (rise[i]) begin
        rpt <= RPT_FIRST;
      end else if (rpt == '0) begin
        rpt <= RPT_NEXT;
      end else begin
        rpt <= rpt - CNT_W'(1);
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  // Opposing direction's post-update level masks both press and repeat pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      control_up     <= 1'b0;
      control_down   <= 1'b0;
      control_select <= 1'b0;
    end else begin
      control_up     <= (rise[0] | rep_fire[0]) & ~db_next[1];
      control_down   <= (rise[1] | rep_fire[1]) & ~db_next[0];
      control_select <= rise[2];
    end
  end

endmodule

// File: tb/tb_joystick_controller.sv
// Bench for joystick_controller: directed scenarios then random stimulus, checked every cycle
// against a sample-history reference model (honours JOYSTICK_REPEAT_EN).
module tb_joystick_controller;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef JOYSTICK_REPEAT_EN
  localparam int EXP_HOLD_RPTS = 4;
`else
  localparam int EXP_HOLD_RPTS = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up_raw = 1'b0;
  logic       btn_down_raw = 1'b0;
  logic       btn_select_raw = 1'b0;
  logic       control_up;
  logic       control_down;
  logic       control_select;
  logic [2:0] held;

  always #5 clock = ~clock;

  joystick_controller #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_up_raw(btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .btn_select_raw(btn_select_raw),
    .control_up(control_up),
    .control_down(control_down),
    .control_select(control_select),
    .held(held)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_up = 0;
  int n_down = 0;
  int n_sel = 0;

  // Reference model: raw samples per edge, debounced levels, run lengths of disagreement
  bit [2:0] raw_q[$];
  bit [2:0] m_db = '0;
  int       run[3];
  bit       e_up = 1'b0;
  bit       e_down = 1'b0;
  bit       e_sel = 1'b0;
  bit [2:0] prev_pulse = '0;
`ifdef JOYSTICK_REPEAT_EN
  int       press_cyc[2];
`endif

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endfunction

  task automatic model_step();
    bit [2:0] s2m;
    bit [2:0] old;
    bit [2:0] rise;
    bit [1:0] rep;
    if (reset) begin
      raw_q.delete();
      m_db = '0;
      for (int b = 0; b < 3; b++) run[b] = 0;
      e_up = 1'b0;
      e_down = 1'b0;
      e_sel = 1'b0;
      return;
    end
    raw_q.push_back({btn_select_raw, btn_down_raw, btn_up_raw});
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    // Debounce logic sees the raw value sampled two edges earlier
    s2m = (raw_q.size() == 3) ? raw_q[0] : 3'b000;
    old = m_db;
    rep = '0;
    for (int b = 0; b < 3; b++) begin
      if (s2m[b] != m_db[b]) begin
        run[b]++;
        if (run[b] == DC) begin
          m_db[b] = s2m[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
    rise = m_db & ~old;
`ifdef JOYSTICK_REPEAT_EN
    for (int b = 0; b < 2; b++) begin
      if (rise[b]) press_cyc[b] = cyc;
      else if (old[b] && m_db[b] && (cyc - press_cyc[b]) >= RD &&
               ((cyc - press_cyc[b] - RD) % RP) == 0)
        rep[b] = 1'b1;
    end
`endif
    e_up   = (rise[0] | rep[0]) & ~m_db[1];
    e_down = (rise[1] | rep[1]) & ~m_db[0];
    e_sel  = rise[2];
  endtask

  task automatic tick();
    bit [2:0] now;
    @(posedge clock);
    cyc++;
    model_step();
    #1;
    now = {control_select, control_down, control_up};
    chk("model_up", 32'(control_up), 32'(e_up));
    chk("model_down", 32'(control_down), 32'(e_down));
    chk("model_select", 32'(control_select), 32'(e_sel));
    chk("model_held", 32'(held), 32'(m_db));
    chk("no_back_to_back", 32'(prev_pulse & now), 32'd0);
    prev_pulse = now;
    n_up   += int'(control_up);
    n_down += int'(control_down);
    n_sel  += int'(control_select);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk("reset_pulses", 32'({control_select, control_down, control_up}), 32'd0);
    chk("reset_held", 32'(held), 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // Clean press: raw rises after edge 0, pulse after edge 6
    tick();
    btn_up_raw = 1'b1;
    repeat (5) tick();
    chk("up_before_latency", 32'(control_up), 32'd0);
    tick();
    chk("up_pulse_edge6", 32'(control_up), 32'd1);
    chk("up_held_edge6", 32'(held), 32'b001);
    n_up = 0;
    repeat (20) tick();
    chk("up_repeats_while_held", 32'(n_up), 32'(EXP_HOLD_RPTS));
    btn_up_raw = 1'b0;
    repeat (5) tick();
    chk("up_held_before_release", 32'(held[0]), 32'd1);
    tick();
    chk("up_released", 32'(held), 32'd0);
    repeat (4) tick();

    // Bounce: 2-cycle toggles then stable high
    n_down = 0;
    for (int k = 0; k < 4; k++) begin
      btn_down_raw = ~k[0];
      tick();
      tick();
    end
    btn_down_raw = 1'b1;
    repeat (5) tick();
    chk("down_before_latency", 32'(control_down), 32'd0);
    tick();
    chk("down_pulse", 32'(control_down), 32'd1);
    repeat (6) tick();
    chk("down_single_pulse", 32'(n_down), 32'd1);
    btn_down_raw = 1'b0;
    repeat (8) tick();

    // Glitch of 3 cycles never accepted
    n_sel = 0;
    btn_select_raw = 1'b1;
    repeat (3) tick();
    btn_select_raw = 1'b0;
    repeat (10) tick();
    chk("glitch_no_pulse", 32'(n_sel), 32'd0);
    chk("glitch_held", 32'(held), 32'd0);

    // Conflict: up and down together
    n_up = 0;
    n_down = 0;
    btn_up_raw = 1'b1;
    btn_down_raw = 1'b1;
    repeat (12) tick();
    chk("conflict_up", 32'(n_up), 32'd0);
    chk("conflict_down", 32'(n_down), 32'd0);
    chk("conflict_held", 32'(held), 32'b011);
    btn_down_raw = 1'b0;
    repeat (8) tick();
    chk("conflict_release_held", 32'(held), 32'b001);
    btn_up_raw = 1'b0;
    repeat (8) tick();
    n_up = 0;
    btn_up_raw = 1'b1;
    repeat (8) tick();
    chk("repress_up", 32'(n_up), 32'd1);
    btn_up_raw = 1'b0;
    repeat (8) tick();

    // Reset mid-hold
    n_sel = 0;
    btn_select_raw = 1'b1;
    repeat (8) tick();
    chk("sel_first", 32'(n_sel), 32'd1);
    reset = 1'b1;
    tick();
    chk("reset_mid_hold_pulses", 32'({control_select, control_down, control_up}), 32'd0);
    chk("reset_mid_hold_held", 32'(held), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk("sel_before_relatch", 32'(control_select), 32'd0);
    tick();
    chk("sel_after_reset", 32'(control_select), 32'd1);
    n_sel = 0;
    repeat (15) tick();
    chk("sel_never_repeats", 32'(n_sel), 32'd0);
    btn_select_raw = 1'b0;
    repeat (8) tick();

    // Random phase
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) btn_up_raw = ~btn_up_raw;
      if ($urandom_range(0, 7) == 0) btn_down_raw = ~btn_down_raw;
      if ($urandom_range(0, 7) == 0) btn_select_raw = ~btn_select_raw;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
